// File: rtl/fw_coef_streamer.sv
// Coefficient ROM reader: walks [base_addr, base_addr+num_words) and serialises each word LSB-first
// onto a valid/ready beat stream. Define FW_PREFETCH_EN to remove the per-word LOAD bubble.
module fw_coef_streamer #(
  parameter int unsigned WIDTH_A = 12,
  parameter int unsigned WORD_W  = 80,
  parameter int unsigned DEPTH   = 120,
  parameter int unsigned BEAT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH_A-1:0] base_addr,
  input  logic [WIDTH_A-1:0] num_words,
  output logic [WIDTH_A-1:0] rom_addr,
  input  logic [WORD_W-1:0]  rom_coef,
  output logic               m_valid,
  output logic [BEAT_W-1:0]  m_data,
  output logic               m_last,
  input  logic               m_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned     BEATS     = WORD_W / BEAT_W;
  localparam int unsigned     BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0]  LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [WIDTH_A:0] DEPTH_X  = (WIDTH_A + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH_A-1:0] cur_q, rem_q, rom_addr_q;
  logic [WORD_W-1:0]  shreg_q;
  logic [BCW-1:0]     beat_q;
  logic               err_q, err_d;
  logic               accept, hs, word_end, more_words;
  logic [WIDTH_A:0]   range_end;

  assign range_end  = {1'b0, base_addr} + {1'b0, num_words};
  assign hs         = (state_q == S_SEND) && m_ready;
  assign word_end   = hs && (beat_q == LAST_BEAT);
  assign more_words = (rem_q != WIDTH_A'(1));
  assign accept     = start && (num_words != '0) && (range_end <= DEPTH_X);

  assign m_valid = (state_q == S_SEND);
  assign m_data  = (state_q == S_SEND) ? shreg_q[BEAT_W-1:0] : '0;
  assign m_last  = (state_q == S_SEND) && !more_words && (beat_q == LAST_BEAT);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FIN);
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rom_addr = rom_addr_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words == '0)        state_d = S_FIN;
          else if (range_end > DEPTH_X) err_d = 1'b1;
          else                        state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rom_addr = cur_q;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (word_end) begin
          if (!more_words) begin
            state_d = S_FIN;
          end else begin
`ifdef FW_PREFETCH_EN
            // next word is fetched in the final-beat cycle so the stream never bubbles
            rom_addr = cur_q + WIDTH_A'(1);
            state_d  = S_SEND;
`else
            state_d  = S_LOAD;
`endif
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= '0;
      rem_q      <= '0;
      rom_addr_q <= '0;
      shreg_q    <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr;
      err_q      <= err_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cur_q <= base_addr;
            rem_q <= num_words;
          end
        end
        S_LOAD: begin
          shreg_q <= rom_coef;
          beat_q  <= '0;
        end
        S_SEND: begin
          if (hs) begin
            shreg_q <= shreg_q >> BEAT_W;
            beat_q  <= beat_q + BCW'(1);
            if (word_end) begin
              rem_q  <= rem_q - WIDTH_A'(1);
              beat_q <= '0;
              if (more_words) begin
                cur_q <= cur_q + WIDTH_A'(1);
`ifdef FW_PREFETCH_EN
                shreg_q <= rom_coef;
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fw_coef_streamer.sv
// Scoreboard bench for fw_coef_streamer: stimulus pushes expected beats, a negedge monitor pops/compares.
module tb_fw_coef_streamer;
  localparam int NB = 5;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
  logic [11:0] base_addr = '0, num_words = '0;
  logic [11:0] rom_addr;
  logic [79:0] rom_coef;
  logic [15:0] m_data;
  logic        m_valid, m_last, busy, done, err;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, start_cyc = 0, mode = 3;
  int hs_cnt = 0, done_cnt = 0, err_cnt = 0, valid_cnt = 0, busy_cnt = 0;
  int fv_cyc = 0, err_cyc = 0;
  logic        prev_stall = 1'b0, prev_last = 1'b0, prev_valid = 1'b0;
  logic [15:0] prev_data = '0;
  logic [16:0] exp_q[$];

  fw_coef_streamer #(.WIDTH_A(12), .WORD_W(80), .DEPTH(120), .BEAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
    .rom_addr(rom_addr), .rom_coef(rom_coef), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [79:0] rom_word(input logic [11:0] a);
    logic [79:0] w;
    w = '0;
    if (a == 12'd0) w = 80'h40C9_2A00_B164_044E_689A;
    else if (a == 12'd119) w = 80'hDADC_9DD4_C8CC_BBDD_7C4F;
    else if (a < 12'd120)
      for (int k = 0; k < NB; k++)
        w[k*16 +: 16] = 16'({4'h0, a} * 16'h9E37) ^ 16'(k * 16'h3C5A) ^ 16'h5A5A;
    return w;
  endfunction

  always_comb rom_coef = rom_word(rom_addr);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall && m_valid) begin
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (m_valid && !prev_valid) fv_cyc = cyc;
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %0h expected none", m_data);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("beat_data", m_data, e[15:0]);
          check("beat_last", m_last, e[16]);
        end
      end
      if (done) done_cnt++;
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (m_valid) valid_cnt++;
      if (busy) busy_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_valid = m_valid;
    end
  end

  task automatic push_range(input int b, input int n);
    logic [79:0] w;
    for (int i = 0; i < n; i++) begin
      w = rom_word(12'(b + i));
      for (int k = 0; k < NB; k++)
        exp_q.push_back({(i == n - 1) && (k == NB - 1), w[k*16 +: 16]});
    end
  endtask

  task automatic start_req(input int b, input int n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'(b); num_words = 12'(n); start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    check("done_seen", got, 1'b1);
  endtask

  function automatic int exp_lat(input int nw);
`ifdef FW_PREFETCH_EN
    return 2 + NB * nw;
`else
    return 1 + (NB + 1) * nw;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, m_valid, 1'b0);
    check({tag, "_data"}, m_data, 16'h0);
    check({tag, "_last"}, m_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_addr"}, rom_addr, 12'h0);
  endtask

  initial begin
    int h0, d0, e0, v0, b0;
    logic seen3;
    #3 check_idle_outputs("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    mode  = 0;

    // 1: single word from address 0
    exp_q.push_back({1'b0, 16'h689A}); exp_q.push_back({1'b0, 16'h044E});
    exp_q.push_back({1'b0, 16'hB164}); exp_q.push_back({1'b0, 16'h2A00});
    exp_q.push_back({1'b1, 16'h40C9});
    h0 = hs_cnt;
    start_req(0, 1);
    wait_done(50);
    check("t1_done_lat", cyc - start_cyc, 7);
    check("t1_first_valid", fv_cyc - start_cyc, 2);
    @(negedge clk);
    check("t1_busy_after", busy, 1'b0);
    check("t1_done_pulse", done, 1'b0);
    check("t1_beats", hs_cnt - h0, NB);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: last address with toggling ready
    mode = 1;
    exp_q.push_back({1'b0, 16'h7C4F}); exp_q.push_back({1'b0, 16'hBBDD});
    exp_q.push_back({1'b0, 16'hC8CC}); exp_q.push_back({1'b0, 16'h9DD4});
    exp_q.push_back({1'b1, 16'hDADC});
    h0 = hs_cnt;
    start_req(119, 1);
    wait_done(100);
    @(negedge clk);
    check("t2_beats", hs_cnt - h0, NB);
    check("t2_q_empty", exp_q.size(), 0);

    // 3: range rejection, exact-fit boundary, zero-length request
    mode = 0;
    e0 = err_cnt; v0 = valid_cnt; b0 = busy_cnt;
    start_req(119, 2);
    repeat (4) @(negedge clk);
    check("t3_err_cnt", err_cnt - e0, 1);
    check("t3_err_cyc", err_cyc - start_cyc, 1);
    check("t3_no_valid", valid_cnt - v0, 0);
    check("t3_no_busy", busy_cnt - b0, 0);
    h0 = hs_cnt; e0 = err_cnt;
    push_range(118, 2);
    start_req(118, 2);
    wait_done(100);
    @(negedge clk);
    check("t3_fit_beats", hs_cnt - h0, 2 * NB);
    check("t3_fit_no_err", err_cnt - e0, 0);
    d0 = done_cnt; v0 = valid_cnt;
    start_req(0, 0);
    wait_done(10);
    check("t3_zero_lat", cyc - start_cyc, 1);
    repeat (3) @(negedge clk);
    check("t3_zero_done", done_cnt - d0, 1);
    check("t3_zero_beats", valid_cnt - v0, 0);

    // 4: whole ROM, random then continuous ready
    mode = 2;
    h0 = hs_cnt;
    push_range(0, 120);
    start_req(0, 120);
    wait_done(6000);
    @(negedge clk);
    check("t4r_beats", hs_cnt - h0, 120 * NB);
    check("t4r_q_empty", exp_q.size(), 0);
    mode = 0;
    h0 = hs_cnt;
    push_range(0, 120);
    start_req(0, 120);
    wait_done(2000);
    check("t4_done_lat", cyc - start_cyc, exp_lat(120));
    @(negedge clk);
    check("t4_beats", hs_cnt - h0, 120 * NB);
    check("t4_q_empty", exp_q.size(), 0);

    // 5: start ignored while busy, then reset during beat 3 of word 0
    h0 = hs_cnt; d0 = done_cnt;
    push_range(0, 2);
    start_req(0, 2);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; base_addr = 12'd5; num_words = 12'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100);
    repeat (4) @(negedge clk);
    check("t5_ign_beats", hs_cnt - h0, 2 * NB);
    check("t5_ign_done", done_cnt - d0, 1);
    check("t5_ign_q_empty", exp_q.size(), 0);

    h0 = hs_cnt; d0 = done_cnt;
    exp_q.push_back({1'b0, 16'h689A}); exp_q.push_back({1'b0, 16'h044E});
    exp_q.push_back({1'b0, 16'hB164});
    start_req(0, 1);
    seen3 = 1'b0;
    for (int i = 0; i < 50 && !seen3; i++) begin
      @(posedge clk);
      seen3 = (hs_cnt - h0 == 3);
    end
    check("t5_reach_beat3", seen3, 1'b1);
    #1 check("t5_beat3_data", m_data, 16'h2A00);
    rst_n = 1'b0;
    #1 check_idle_outputs("abort");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_abort_done", done_cnt - d0, 0);
    check("t5_abort_q_empty", exp_q.size(), 0);
    h0 = hs_cnt;
    push_range(0, 1);
    start_req(0, 1);
    wait_done(50);
    check("t5_fresh_lat", cyc - start_cyc, 7);
    @(negedge clk);
    check("t5_fresh_beats", hs_cnt - h0, NB);
    check("t5_fresh_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
